// File: rtl/stream_select_mux_if.sv
// -----------------------------------------------------------------------------
// stream_select_mux_if
// Bundle of the selector controls, the CHANNELS input streams and the single
// output stream of stream_select_mux.
//   mode        0 = address select, 1 = round-robin
//   address     channel picked in address mode
//   in_data     channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid    per-channel valid
//   in_ready    per-channel ready (combinational, driven by the mux)
//   out_data    registered selected word
//   out_channel registered index of the channel out_data came from
//   out_valid   registered output valid
//   out_ready   consumer ready
// Modports: slave = the mux itself, master = producers/consumer around it.
// -----------------------------------------------------------------------------
interface stream_select_mux_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 2
);
  localparam int CHANNELS = 1 << ADDR_WIDTH;

  logic                      mode;
  logic [ADDR_WIDTH-1:0]     address;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [ADDR_WIDTH-1:0]     out_channel;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  mode, address, in_data, in_valid, out_ready,
    output in_ready, out_data, out_channel, out_valid
  );

  modport master (
    output mode, address, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_channel, out_valid
  );
endinterface

// File: rtl/stream_select_mux.sv
// -----------------------------------------------------------------------------
// stream_select_mux
// Selects one of CHANNELS = 2**ADDR_WIDTH valid/ready input streams and forwards
// it into a single registered output stream. Address mode picks the channel
// given on `address`; round-robin mode grants the first valid channel after the
// one that last transferred, wrapping around.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    stream_select_mux_if.slave (controls, input streams, output stream)
// -----------------------------------------------------------------------------
module stream_select_mux #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  stream_select_mux_if.slave    bus
);
  localparam int CHANNELS = 1 << ADDR_WIDTH;

  // Output register and round-robin pointer.
  logic [WIDTH-1:0]      r_out_data;
  logic [ADDR_WIDTH-1:0] r_out_channel;
  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_last;

  logic                  w_load;
  logic [CHANNELS-1:0]   w_grant;
  logic [ADDR_WIDTH-1:0] w_grant_idx;
  logic [ADDR_WIDTH-1:0] w_cand;
  logic                  w_found;
  logic [CHANNELS-1:0]   w_in_ready;
  logic                  w_xfer;
  logic [WIDTH-1:0]      w_sel_data;

  // The output register can take a word when empty or when being drained now.
  assign w_load = !r_out_valid || bus.out_ready;

  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    w_grant     = '0;
    w_grant_idx = '0;
    w_cand      = '0;
    w_found     = 1'b0;
    if (!bus.mode) begin
      w_grant_idx = bus.address;
      if (bus.in_valid[bus.address]) begin
        w_grant[bus.address] = 1'b1;
        w_found              = 1'b1;
      end
    end else begin
      // Search last+1, last+2, ... modulo CHANNELS; the ADDR_WIDTH-bit sum
      // wraps naturally, giving the required wrap-around order.
      for (int k = 0; k < CHANNELS; k++) begin
        w_cand = r_last + ADDR_WIDTH'(k + 1);
        if (!w_found && bus.in_valid[w_cand]) begin
          w_grant[w_cand] = 1'b1;
          w_grant_idx     = w_cand;
          w_found         = 1'b1;
        end
      end
    end
  end

  // Grant is already qualified by in_valid, so any ready bit means a transfer.
  assign w_in_ready = w_grant & {CHANNELS{w_load && !reset}};
  assign w_xfer     = |w_in_ready;
  assign w_sel_data = bus.in_data[w_grant_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_out_data    <= '0;
      r_out_channel <= '0;
      r_out_valid   <= 1'b0;
      // Pointer at the last channel makes channel 0 first in line after reset.
      r_last        <= ADDR_WIDTH'(CHANNELS - 1);
    end else if (w_xfer) begin
      // Covers simultaneous drain and load: out_valid stays high, no bubble.
      r_out_data    <= w_sel_data;
      r_out_channel <= w_grant_idx;
      r_out_valid   <= 1'b1;
      r_last        <= w_grant_idx;
    end else if (bus.out_ready) begin
      // Drained with nothing new: data/channel keep their last values.
      r_out_valid   <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_data    = r_out_data;
  assign bus.out_channel = r_out_channel;
  assign bus.out_valid   = r_out_valid;

endmodule
